// File: rtl/muldiv_hilo_pkg.sv
// Shared ALU control codes and FSM state encoding for the HI/LO multiply/divide unit.
package muldiv_hilo_pkg;

   localparam logic [4:0] MULT_CONTROL = 5'b01010;
   localparam logic [4:0] DIV_CONTROL  = 5'b01011;
   localparam logic [4:0] MTHI_CONTROL = 5'b01100;
   localparam logic [4:0] MTLO_CONTROL = 5'b01101;

   typedef enum logic [2:0] {
      StIdle,
      StMul,
      StDiv,
      StFix,
      StDone
   } state_e;

endpackage

// File: rtl/muldiv_hilo_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface muldiv_hilo_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start_i;
   logic [4:0]       alucontrol_i;
   logic             signed_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             flush_i;
   logic             stall_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, alucontrol_i, signed_i, a_i, b_i, flush_i,
      input  stall_o, done_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, alucontrol_i, signed_i, a_i, b_i, flush_i,
      output stall_o, done_o, hi_o, lo_o
   );

endinterface

// File: rtl/muldiv_hilo_div_radix2.sv
// Unsigned radix-2 restoring divider: one shift-subtract step per cycle on magnitudes.
module muldiv_hilo_div_radix2 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITERS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_done
);

   localparam int unsigned     CntW    = $clog2(ITERS);
   localparam logic [CntW-1:0] LastCnt = CntW'(ITERS - 1);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic [CntW-1:0]  r_cnt;
   logic             r_busy;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_fits;

   // Dividend bits enter the partial remainder MSB-first; r_quo doubles as the shift source.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_div};
   assign w_fits  = ~w_trial[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_abort) begin
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_div  <= i_divisor;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem  <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
         r_quo  <= {r_quo[WIDTH-2:0], w_fits};
         r_cnt  <= r_cnt + CntW'(1);
         if (r_cnt == LastCnt) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done      = r_busy & (r_cnt == LastCnt);
   assign o_quotient  = r_quo;
   assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage multiply/divide unit with architectural HI/LO and a combinational pipeline stall.
module muldiv_hilo
   import muldiv_hilo_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DIV_ITERS = 32
) (
   input logic           clk,
   input logic           rst,
   muldiv_hilo_if.slave  io_bus
);

   state_e r_state;
   state_e w_state_next;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_signed;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_div_zero;

   logic               w_is_mul;
   logic               w_is_div;
   logic               w_is_mthi;
   logic               w_is_mtlo;
   logic               w_issue;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [2*WIDTH-1:0] w_a_ext;
   logic [2*WIDTH-1:0] w_b_ext;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;
   logic               w_div_done;

   assign w_is_mul  = (io_bus.alucontrol_i == MULT_CONTROL);
   assign w_is_div  = (io_bus.alucontrol_i == DIV_CONTROL);
   assign w_is_mthi = (io_bus.alucontrol_i == MTHI_CONTROL);
   assign w_is_mtlo = (io_bus.alucontrol_i == MTLO_CONTROL);
   assign w_issue   = (r_state == StIdle) & io_bus.start_i & ~io_bus.flush_i;

   assign w_a_neg = io_bus.signed_i & io_bus.a_i[WIDTH-1];
   assign w_b_neg = io_bus.signed_i & io_bus.b_i[WIDTH-1];
   assign w_abs_a = w_a_neg ? -io_bus.a_i : io_bus.a_i;
   assign w_abs_b = w_b_neg ? -io_bus.b_i : io_bus.b_i;

   // Sign/zero-extend to 2*WIDTH so one truncated multiply serves MULT and MULTU.
   assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
   assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
   assign w_prod  = w_a_ext * w_b_ext;

   muldiv_hilo_div_radix2 #(
      .WIDTH (WIDTH),
      .ITERS (DIV_ITERS)
   ) u_div (
      .clk         (clk),
      .rst         (rst),
      .i_start     (w_issue & w_is_div),
      .i_abort     (io_bus.flush_i),
      .i_dividend  (w_abs_a),
      .i_divisor   (w_abs_b),
      .o_quotient  (w_quo),
      .o_remainder (w_rem),
      .o_done      (w_div_done)
   );

   assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
   assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      io_bus.stall_o = 1'b0;
      io_bus.done_o  = 1'b0;
      case (r_state)
         StIdle: begin
            if (w_issue & w_is_mul) begin
               w_state_next = StMul;
            end else if (w_issue & w_is_div) begin
               w_state_next = StDiv;
            end
            io_bus.stall_o = w_issue & (w_is_mul | w_is_div);
         end
         StMul: begin
            io_bus.stall_o = 1'b1;
            w_state_next   = io_bus.flush_i ? StIdle : StDone;
         end
         StDiv: begin
            io_bus.stall_o = 1'b1;
            if (io_bus.flush_i) begin
               w_state_next = StIdle;
            end else if (w_div_done) begin
               w_state_next = StFix;
            end
         end
         StFix: begin
            io_bus.stall_o = 1'b1;
            w_state_next   = io_bus.flush_i ? StIdle : StDone;
         end
         StDone: begin
            // Commit already happened: start_i and flush_i are both ignored here.
            io_bus.done_o = 1'b1;
            w_state_next  = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_signed   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_div_zero <= 1'b0;
      end else if (w_issue & (w_is_mul | w_is_div)) begin
         r_a        <= io_bus.a_i;
         r_b        <= io_bus.b_i;
         r_signed   <= io_bus.signed_i;
         r_neg_q    <= w_a_neg ^ w_b_neg;
         r_neg_r    <= w_a_neg;
         r_div_zero <= (io_bus.b_i == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_issue & w_is_mthi) r_hi <= io_bus.a_i;
               if (w_issue & w_is_mtlo) r_lo <= io_bus.a_i;
            end
            StMul: begin
               if (!io_bus.flush_i) {r_hi, r_lo} <= w_prod;
            end
            StFix: begin
               if (!io_bus.flush_i) begin
                  r_hi <= r_div_zero ? r_a : w_rem_fix;
                  r_lo <= r_div_zero ? '1 : w_quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.hi_o = r_hi;
   assign io_bus.lo_o = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo: mul/div results, stall timing, HI/LO moves,
// flush and asynchronous reset mid-operation.
module tb_muldiv_hilo;
   import muldiv_hilo_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   muldiv_hilo_if #(.WIDTH(32)) bus ();

   muldiv_hilo #(
      .WIDTH     (32),
      .DIV_ITERS (32)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // Holds start_i through the whole op, like a stalled EX stage, and drops it after DONE.
   task automatic run_op(input logic [4:0] code, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, output int stalls, output int dones);
      logic d;
      bus.start_i      = 1'b1;
      bus.alucontrol_i = code;
      bus.signed_i     = sgn;
      bus.a_i          = a;
      bus.b_i          = b;
      stalls           = 0;
      dones            = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.stall_o) stalls++;
         d = bus.done_o;
         if (d) dones++;
         @(posedge clk);
         #1;
         if (d) break;
      end
      bus.start_i = 1'b0;
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      bus.start_i      = 1'b0;
      bus.alucontrol_i = 5'd0;
      bus.signed_i     = 1'b0;
      bus.a_i          = '0;
      bus.b_i          = '0;
      bus.flush_i      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
      n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
      n_cmp++; if (bus.hi_o !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 00000000", bus.hi_o); end
      n_cmp++; if (bus.lo_o !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 00000000", bus.lo_o); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_mult();
      int s, d;
      run_op(MULT_CONTROL, 1'b1, 32'hFFFF_FFFE, 32'd3, s, d);
      n_cmp++; if (s !== 2) begin n_err++; $display("FAIL mult_stall: got %0d want 2", s); end
      n_cmp++; if (d !== 1) begin n_err++; $display("FAIL mult_done: got %0d want 1", d); end
      n_cmp++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi_o); end
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo_o); end
      run_op(MULT_CONTROL, 1'b0, 32'hFFFF_FFFE, 32'd3, s, d);
      n_cmp++; if (bus.hi_o !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", bus.hi_o); end
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", bus.lo_o); end
   endtask

   task automatic test_div();
      int s, d;
      run_op(DIV_CONTROL, 1'b1, 32'hFFFF_FFF9, 32'd2, s, d);
      n_cmp++; if (s !== 34) begin n_err++; $display("FAIL div_stall: got %0d want 34", s); end
      n_cmp++; if (d !== 1) begin n_err++; $display("FAIL div_done: got %0d want 1", d); end
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", bus.lo_o); end
      n_cmp++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", bus.hi_o); end
      run_op(DIV_CONTROL, 1'b0, 32'd100, 32'd7, s, d);
      n_cmp++; if (bus.lo_o !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo_o); end
      n_cmp++; if (bus.hi_o !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h want 00000002", bus.hi_o); end
   endtask

   task automatic test_div_edges();
      int s, d;
      run_op(DIV_CONTROL, 1'b0, 32'h0000_1234, 32'd0, s, d);
      n_cmp++; if (s !== 34) begin n_err++; $display("FAIL divz_stall: got %0d want 34", s); end
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_lo: got %h want ffffffff", bus.lo_o); end
      n_cmp++; if (bus.hi_o !== 32'h0000_1234) begin n_err++; $display("FAIL divz_hi: got %h want 00001234", bus.hi_o); end
      run_op(DIV_CONTROL, 1'b1, 32'hFFFF_FFF9, 32'd0, s, d);
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_s_lo: got %h want ffffffff", bus.lo_o); end
      n_cmp++; if (bus.hi_o !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL divz_s_hi: got %h want fffffff9", bus.hi_o); end
      run_op(DIV_CONTROL, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, s, d);
      n_cmp++; if (bus.lo_o !== 32'h8000_0000) begin n_err++; $display("FAIL divovf_lo: got %h want 80000000", bus.lo_o); end
      n_cmp++; if (bus.hi_o !== 32'h0) begin n_err++; $display("FAIL divovf_hi: got %h want 00000000", bus.hi_o); end
   endtask

   task automatic test_mthi_mtlo();
      bus.start_i      = 1'b1;
      bus.alucontrol_i = MTHI_CONTROL;
      bus.a_i          = 32'hA5A5_A5A5;
      @(negedge clk);
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL mthi_stall: got %b want 0", bus.stall_o); end
      @(posedge clk);
      #1;
      bus.alucontrol_i = MTLO_CONTROL;
      bus.a_i          = 32'h5A5A_5A5A;
      @(negedge clk);
      n_cmp++; if (bus.hi_o !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi_hi: got %h want a5a5a5a5", bus.hi_o); end
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL mtlo_stall: got %b want 0", bus.stall_o); end
      @(posedge clk);
      #1;
      // Flush in IDLE must mask a move as well.
      bus.alucontrol_i = MTHI_CONTROL;
      bus.a_i          = 32'hDEAD_BEEF;
      bus.flush_i      = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.lo_o !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL mtlo_lo: got %h want 5a5a5a5a", bus.lo_o); end
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.hi_o !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi_flush: got %h want a5a5a5a5", bus.hi_o); end
   endtask

   task automatic test_flush();
      int d = 0;
      @(posedge clk);
      #1;
      bus.start_i      = 1'b1;
      bus.alucontrol_i = DIV_CONTROL;
      bus.signed_i     = 1'b0;
      bus.a_i          = 32'd100;
      bus.b_i          = 32'd7;
      repeat (11) @(posedge clk);
      #1;
      bus.flush_i = 1'b1;
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b want 0", bus.stall_o); end
      n_cmp++; if (bus.hi_o !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL flush_hi: got %h want a5a5a5a5", bus.hi_o); end
      n_cmp++; if (bus.lo_o !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL flush_lo: got %h want 5a5a5a5a", bus.lo_o); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done_o) d++;
      end
      n_cmp++; if (d !== 0) begin n_err++; $display("FAIL flush_nodone: got %0d pulses want 0", d); end
   endtask

   task automatic test_back_to_back();
      int s, d, busy;
      @(posedge clk);
      #1;
      run_op(MULT_CONTROL, 1'b0, 32'd5, 32'd7, s, d);
      n_cmp++; if (d !== 1) begin n_err++; $display("FAIL b2b_done: got %0d want 1", d); end
      n_cmp++; if (bus.lo_o !== 32'd35) begin n_err++; $display("FAIL b2b_lo: got %h want 00000023", bus.lo_o); end
      busy = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.stall_o || bus.done_o) busy++;
      end
      n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL b2b_reissue: got %0d busy cycles want 0", busy); end
      // Unknown control code is ignored.
      @(posedge clk);
      #1;
      bus.start_i      = 1'b1;
      bus.alucontrol_i = 5'd0;
      bus.a_i          = 32'h1111_1111;
      @(negedge clk);
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL other_stall: got %b want 0", bus.stall_o); end
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'd35) begin
         n_err++; $display("FAIL other_hilo: got %h/%h want 00000000/00000023", bus.hi_o, bus.lo_o);
      end
   endtask

   task automatic test_rst_mid();
      int s, d;
      @(posedge clk);
      #1;
      bus.start_i      = 1'b1;
      bus.alucontrol_i = DIV_CONTROL;
      bus.signed_i     = 1'b0;
      bus.a_i          = 32'd100;
      bus.b_i          = 32'd7;
      repeat (11) @(posedge clk);
      #1;
      rst         = 1'b1;
      bus.start_i = 1'b0;
      #1;
      n_cmp++; if (bus.hi_o !== 32'h0) begin n_err++; $display("FAIL rst_hi: got %h want 00000000", bus.hi_o); end
      n_cmp++; if (bus.lo_o !== 32'h0) begin n_err++; $display("FAIL rst_lo: got %h want 00000000", bus.lo_o); end
      n_cmp++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
      @(posedge clk);
      #1 rst = 1'b0;
      run_op(MULT_CONTROL, 1'b1, 32'd3, 32'hFFFF_FFFE, s, d);
      n_cmp++; if (s !== 2 || d !== 1) begin n_err++; $display("FAIL rst_recover: got stall %0d done %0d want 2 1", s, d); end
      n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL rst_recover_lo: got %h want fffffffa", bus.lo_o); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_edges();
      test_mthi_mtlo();
      test_flush();
      test_back_to_back();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
